// File: rtl/spi_fifo_pkg.sv
// Shared definitions for the SPI watermark FIFO: reset constants, threshold
// comparator kinds and the occupancy-width helper.
package spi_fifo_pkg;

  typedef enum logic {
    LVL_CMP_GE,
    LVL_CMP_LE
  } lvl_cmp_e;

  localparam int unsigned RST_PTR  = 0;
  localparam logic        RST_FLAG = 1'b0;

  // Occupancy needs one bit more than the address so full and empty differ.
  function automatic int occ_bits(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/spi_fifo_lvl_evt.sv
// Threshold comparator with a one-cycle pulse when the occupancy crosses
// into the compared region; a threshold change by itself never pulses.
module spi_fifo_lvl_evt
  import spi_fifo_pkg::*;
#(
  parameter int       CNT_W = 5,
  parameter lvl_cmp_e CMP   = LVL_CMP_GE
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic [CNT_W-1:0] lvl_i,
  output logic             lvl_o,
  output logic             evt_o
);

  logic [CNT_W-1:0] cnt_prev_reg;
  logic             evt_reg;
  logic             cur_hit;
  logic             prev_hit;

  function automatic logic hit(input logic [CNT_W-1:0] c, input logic [CNT_W-1:0] l);
    return (CMP == LVL_CMP_GE) ? (c >= l) : (c <= l);
  endfunction

  // Both sides use the current threshold, so only occupancy movement can flip them.
  assign cur_hit  = hit(cnt_i, lvl_i);
  assign prev_hit = hit(cnt_prev_reg, lvl_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_prev_reg <= CNT_W'(RST_PTR);
      evt_reg      <= RST_FLAG;
    end else if (clr_i) begin
      cnt_prev_reg <= CNT_W'(RST_PTR);
      evt_reg      <= RST_FLAG;
    end else begin
      cnt_prev_reg <= cnt_i;
      evt_reg      <= cur_hit & ~prev_hit;
    end
  end

  assign lvl_o = cur_hit;
  assign evt_o = evt_reg;

endmodule

// File: rtl/spi_wm_fifo.sv
// Show-ahead synchronous FIFO with watermark flags, crossing events and sticky
// overrun/underrun errors. Define SPI_FIFO_PEAK_TRACK_EN to add high-water tracking.
module spi_wm_fifo
  import spi_fifo_pkg::*;
#(
  parameter int FIFO_WIDTH    = 32,
  parameter int FIFO_DEPTH    = 16,
  parameter int FIFO_PTR_BITS = $clog2(FIFO_DEPTH)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clr_i,
  input  logic                   wr_i,
  input  logic [FIFO_WIDTH-1:0]  wdata_i,
  input  logic                   rd_i,
  input  logic [FIFO_PTR_BITS:0] lvl_lo_i,
  input  logic [FIFO_PTR_BITS:0] lvl_hi_i,
  output logic [FIFO_WIDTH-1:0]  rdata_o,
  output logic [FIFO_PTR_BITS:0] cnt_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   almost_full_o,
  output logic                   almost_empty_o,
  output logic                   hi_evt_o,
  output logic                   lo_evt_o,
  output logic                   ovr_run_o,
  output logic                   udr_run_o,
  input  logic                   ovr_run_clr_i,
  input  logic                   udr_run_clr_i,
`ifdef SPI_FIFO_PEAK_TRACK_EN
  input  logic                   peak_clr_i,
`endif
  output logic [FIFO_PTR_BITS:0] peak_o
);

  localparam int CNT_W = occ_bits(FIFO_DEPTH);
  typedef logic [CNT_W-1:0] occ_t;

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

  occ_t head_reg, tail_reg;
  occ_t head_next, tail_next;
  occ_t cnt;
  logic full, empty;
  logic push, pop;
  logic ovr_reg, udr_reg;

  assign cnt   = head_reg - tail_reg;
  assign full  = (cnt == occ_t'(FIFO_DEPTH));
  assign empty = (cnt == '0);

  // A push into a full FIFO is fine when a pop frees the head slot the same cycle.
  assign push = wr_i & (~full | rd_i);
  assign pop  = rd_i & ~empty;

  always_comb begin
    head_next = head_reg;
    tail_next = tail_reg;
    if (clr_i) begin
      head_next = occ_t'(RST_PTR);
      tail_next = occ_t'(RST_PTR);
    end else begin
      if (push) head_next = head_reg + occ_t'(1);
      if (pop)  tail_next = tail_reg + occ_t'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_reg <= occ_t'(RST_PTR);
      tail_reg <= occ_t'(RST_PTR);
    end else begin
      head_reg <= head_next;
      tail_reg <= tail_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !clr_i) mem[head_reg[FIFO_PTR_BITS-1:0]] <= wdata_i;
  end

  assign rdata_o = mem[tail_reg[FIFO_PTR_BITS-1:0]];

  // Error sets win over same-cycle clears; a flush wipes both.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ovr_reg <= RST_FLAG;
      udr_reg <= RST_FLAG;
    end else if (clr_i) begin
      ovr_reg <= RST_FLAG;
      udr_reg <= RST_FLAG;
    end else begin
      ovr_reg <= (wr_i & ~push) | (ovr_reg & ~ovr_run_clr_i);
      udr_reg <= (rd_i & empty) | (udr_reg & ~udr_run_clr_i);
    end
  end

  spi_fifo_lvl_evt #(.CNT_W(CNT_W), .CMP(LVL_CMP_GE)) u_hi_evt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (clr_i),
    .cnt_i (cnt),
    .lvl_i (lvl_hi_i),
    .lvl_o (almost_full_o),
    .evt_o (hi_evt_o)
  );

  spi_fifo_lvl_evt #(.CNT_W(CNT_W), .CMP(LVL_CMP_LE)) u_lo_evt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (clr_i),
    .cnt_i (cnt),
    .lvl_i (lvl_lo_i),
    .lvl_o (almost_empty_o),
    .evt_o (lo_evt_o)
  );

`ifdef SPI_FIFO_PEAK_TRACK_EN
  occ_t cnt_next;
  occ_t peak_reg;

  assign cnt_next = head_next - tail_next;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      peak_reg <= occ_t'(RST_PTR);
    end else if (peak_clr_i || clr_i) begin
      peak_reg <= occ_t'(RST_PTR);
    end else if (cnt_next > peak_reg) begin
      peak_reg <= cnt_next;
    end
  end

  assign peak_o = peak_reg;
`else
  assign peak_o = '0;
`endif

  assign cnt_o     = cnt;
  assign full_o    = full;
  assign empty_o   = empty;
  assign ovr_run_o = ovr_reg;
  assign udr_run_o = udr_reg;

endmodule
